// File: rtl/pu_dot_sequencer.sv
// Operand sequencer and result collector for the combinational processor_unit
// MAC (out = previous + a0*b0 + a1*b1). Streams float32 operand pairs in two
// at a time, feeds each MAC result back as the next 'previous', and returns
// the final accumulated value on a valid/ready result port. No arithmetic is
// done here; every value moves bit-exact.
module pu_dot_sequencer #(
  parameter int VEC_LEN = 8  // element pairs per vector, even and >= 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] init_acc,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] pu_previous,
  output logic [31:0] pu_array1_0,
  output logic [31:0] pu_array2_0,
  output logic [31:0] pu_array1_1,
  output logic [31:0] pu_array2_1,
  input  logic [31:0] pu_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy
);

  localparam int CW = $clog2(VEC_LEN + 1);

  typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, CALC, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            last_grp;
  logic [31:0]     acc;
  logic            hs;

  assign hs          = in_valid & in_ready;
  assign cnt_nxt     = cnt + CW'(2);
  assign last_grp    = (cnt_nxt == CW'(VEC_LEN));
  assign pu_previous = acc;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: LOAD states wait on the source, DONE waits on the sink
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = LOAD0;
      LOAD0:   if (hs)        state_nxt = LOAD1;
      LOAD1:   if (hs)        state_nxt = CALC;
      CALC:    state_nxt = last_grp ? DONE : LOAD0;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LOAD0, LOAD1: in_ready  = 1'b1;
      DONE:         res_valid = 1'b1;
      default:      ;
    endcase
    // Result bus reads zero whenever no result is being offered
    res_data = res_valid ? acc : 32'h0;
  end

  // Datapath: accumulator, pair counter and MAC operand registers. Operand
  // registers are deliberately not cleared by start; they hold across vectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= 32'h0;
      cnt         <= '0;
      pu_array1_0 <= 32'h0;
      pu_array2_0 <= 32'h0;
      pu_array1_1 <= 32'h0;
      pu_array2_1 <= 32'h0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc <= init_acc;
          cnt <= '0;
        end
        LOAD0: if (hs) begin
          pu_array1_0 <= in_a;
          pu_array2_0 <= in_b;
        end
        LOAD1: if (hs) begin
          pu_array1_1 <= in_a;
          pu_array2_1 <= in_b;
        end
        CALC: begin
          // processor_unit has settled on the operands loaded last cycle
          acc <= pu_out;
          cnt <= cnt_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule
